gray_code_counter: RTL and testbench

//   Parameterised up/down counter that presents its count as registered Gray code.
//   It is the encoding-side counterpart of the 4-bit Gray-to-binary decoder.
//   It produces Gray-coded pointers/positions for downstream decode and clock-domain-safe sampling.

---
 rtl/gray_code_counter_if.sv | 30 +++
 rtl/gray_code_counter.sv | 89 ++++++++
 tb/tb_gray_code_counter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gray_code_counter_if.sv
// Interface bundling the control and status signals of gray_code_counter.
//   en       count enable
//   up_dn    direction (1 = up, 0 = down)
//   load     synchronous load strobe (wins over en)
//   load_bin binary value to load
//   gray     registered Gray code of the count
//   bin      registered binary count
//   term     one-cycle terminal-count pulse
// The master modport drives the controls; the slave modport is the counter.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             term;

    modport master (
        output en, up_dn, load, load_bin,
        input  gray, bin, term
    );

    modport slave (
        input  en, up_dn, load, load_bin,
        output gray, bin, term
    );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter whose count is also presented as registered Gray
// code. bin and gray are both registered from the same next-state value, so
// gray is always the code of bin and changes one bit per counting step.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset (bin, gray and term forced to 0)
//   bus   gray_code_counter_if slave modport (en, up_dn, load, load_bin in;
//         gray, bin, term out)
// Parameters:
//   WIDTH   counter width (>= 2); must match the interface WIDTH
//   WRAP_EN 1 = wrap at the terminal count, 0 = saturate there
module gray_code_counter #(
    parameter int WIDTH   = 4,
    parameter int WRAP_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_code_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               WRAP_C = (WRAP_EN != 0);

    // Binary-to-Gray: MSB passes through, every other bit XORs with its upper neighbour.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             term_r;
    logic [WIDTH-1:0] bin_next_s;
    logic             term_next_s;

    // Next-count selection: load beats en, en beats hold; terminal handling by WRAP_C.
    always_comb begin
        bin_next_s  = bin_r;
        term_next_s = 1'b0;
        if (bus.load) begin
            bin_next_s = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (bin_r == MAX_C) begin
                    term_next_s = 1'b1;
                    if (WRAP_C) begin
                        bin_next_s = ZERO_C;
                    end else begin
                        bin_next_s = MAX_C;
                    end
                end else begin
                    bin_next_s = bin_r + ONE_C;
                end
            end else begin
                if (bin_r == ZERO_C) begin
                    term_next_s = 1'b1;
                    if (WRAP_C) begin
                        bin_next_s = MAX_C;
                    end else begin
                        bin_next_s = ZERO_C;
                    end
                end else begin
                    bin_next_s = bin_r - ONE_C;
                end
            end
        end else begin
            bin_next_s = bin_r;
        end
    end

    // Output registers; gray is encoded from the next binary value so both update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= ZERO_C;
            gray_r <= ZERO_C;
            term_r <= 1'b0;
        end else begin
            bin_r  <= bin_next_s;
            gray_r <= bin2gray(bin_next_s);
            term_r <= term_next_s;
        end
    end

    assign bus.bin  = bin_r;
    assign bus.gray = gray_r;
    assign bus.term = term_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter: one wrapping and one saturating
// instance share the same stimulus; both are compared against an integer
// reference model every cycle, plus directed expectations.
module tb_gray_code_counter;

    localparam int W   = 4;
    localparam int MAX = 15;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   m_bin_w, m_bin_s;
    bit   m_term_w, m_term_s;

    gray_code_counter_if #(.WIDTH(W)) ifw ();
    gray_code_counter_if #(.WIDTH(W)) ifs ();

    assign ifs.en       = ifw.en;
    assign ifs.up_dn    = ifw.up_dn;
    assign ifs.load     = ifw.load;
    assign ifs.load_bin = ifw.load_bin;

    gray_code_counter #(.WIDTH(W), .WRAP_EN(1)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));
    gray_code_counter #(.WIDTH(W), .WRAP_EN(0)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference step: counting rules in plain integer arithmetic.
    function automatic int ref_next(input int b, input bit wrap, input bit en, input bit up,
                                    input bit ld, input int lb, output bit t);
        t = 1'b0;
        if (ld) return lb;
        if (!en) return b;
        if (up) begin
            if (b == MAX) begin t = 1'b1; return wrap ? 0 : MAX; end
            return b + 1;
        end
        if (b == 0) begin t = 1'b1; return wrap ? MAX : 0; end
        return b - 1;
    endfunction

    function automatic int gcode(input int b);
        return (b ^ (b >> 1)) & MAX;
    endfunction

    task automatic check_outputs();
        chk("bin_w",  int'(ifw.bin),  m_bin_w);
        chk("gray_w", int'(ifw.gray), gcode(m_bin_w));
        chk("term_w", int'(ifw.term), int'(m_term_w));
        chk("bin_s",  int'(ifs.bin),  m_bin_s);
        chk("gray_s", int'(ifs.gray), gcode(m_bin_s));
        chk("term_s", int'(ifs.term), int'(m_term_s));
    endtask

    // One clock: advance the model with the applied inputs, then compare after the edge.
    task automatic cycle();
        logic [W-1:0] pg_w, pg_s;
        int pb_w, pb_s;
        bit ld, en;
        pg_w = ifw.gray; pg_s = ifs.gray;
        pb_w = m_bin_w;  pb_s = m_bin_s;
        ld = ifw.load;   en = ifw.en;
        m_bin_w = ref_next(m_bin_w, 1'b1, en, ifw.up_dn, ld, int'(ifw.load_bin), m_term_w);
        m_bin_s = ref_next(m_bin_s, 1'b0, en, ifw.up_dn, ld, int'(ifw.load_bin), m_term_s);
        @(posedge clk);
        #1;
        check_outputs();
        if (!ld && en) begin
            chk("ham_w", $countones(pg_w ^ ifw.gray), (m_bin_w != pb_w) ? 1 : 0);
            chk("ham_s", $countones(pg_s ^ ifs.gray), (m_bin_s != pb_s) ? 1 : 0);
        end
    endtask

    task automatic drive(input bit ld, input int lb, input bit en, input bit up);
        ifw.load     = ld;
        ifw.load_bin = lb[W-1:0];
        ifw.en       = en;
        ifw.up_dn    = up;
    endtask

    initial begin
        int exp_gray [17];
        int exp_dn   [7];
        n_cmp = 0; n_err = 0;
        exp_gray = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
        exp_dn   = '{4, 3, 2, 1, 0, 15, 14};
        m_bin_w = 0; m_bin_s = 0; m_term_w = 1'b0; m_term_s = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        #12;
        check_outputs();
        rst_n = 1'b1;

        // Test 1: count up through a full wrap.
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("t1_gray", int'(ifw.gray), exp_gray[i+1]);
            chk("t1_term", int'(ifw.term), (i == 15) ? 1 : 0);
        end

        // Test 2: load 5 then count down through 0.
        drive(1'b1, 5, 1'b0, 1'b0);
        cycle();
        chk("t2_load_gray", int'(ifw.gray), 7);
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("t2_bin",  int'(ifw.bin),  exp_dn[i]);
            chk("t2_term", int'(ifw.term), (i == 5) ? 1 : 0);
        end

        // Test 3: saturation at both ends on the non-wrapping instance.
        drive(1'b1, 14, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_bin",  int'(ifs.bin),  15);
            chk("t3_gray", int'(ifs.gray), 8);
            chk("t3_term", int'(ifs.term), (i == 0) ? 0 : 1);
        end
        drive(1'b1, 1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3d_bin",  int'(ifs.bin),  0);
            chk("t3d_term", int'(ifs.term), (i == 0) ? 0 : 1);
        end

        // Test 4: load wins over en; reload of the same value is a no-op.
        drive(1'b1, 9, 1'b1, 1'b1);
        cycle();
        chk("t4_bin",  int'(ifw.bin),  9);
        chk("t4_gray", int'(ifw.gray), 13);
        chk("t4_term", int'(ifw.term), 0);
        cycle();
        chk("t4_reload_bin", int'(ifw.bin), 9);

        // Test 5: asynchronous reset between edges.
        drive(1'b1, 10, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 0, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        m_bin_w = 0; m_bin_s = 0; m_term_w = 1'b0; m_term_s = 1'b0;
        chk("t5_bin_async",  int'(ifw.bin),  0);
        chk("t5_gray_async", int'(ifw.gray), 0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("t5_resume", int'(ifw.bin), 1);

        // Test 6: random stimulus against the model.
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 15) == 0), int'($urandom_range(0, MAX)),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
